// File: rtl/decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Drives the select lines {a,b,c} and the enable of a downstream 3-to-8
// decoder. It walks a programmable subset of the eight decoder outputs,
// holding each one for DWELL cycles with enable high. An optional BLANK-cycle
// gap with enable low separates consecutive channels. A sweep is either
// one-shot, ending with a single-cycle done pulse, or continuous, wrapping
// until it is stopped.
//
// Parameters
//   DWELL    cycles the enable is held high per visited channel (1..255)
//   BLANK    cycles the enable is held low between channels    (0..255)
//
// Ports
//   i_clk    single clock, rising edge
//   i_rst    synchronous, active-high reset
//   i_start  sweep request, sampled only while idle
//   i_stop   abort, sampled in every state (wins over i_start)
//   i_mode   0 = one-shot, 1 = continuous (latched with i_start)
//   i_mask   bit i set = visit channel i   (latched with i_start)
//   o_a      channel index bit 2
//   o_b      channel index bit 1
//   o_c      channel index bit 0
//   o_en     decoder enable, high only while driving a channel
//   o_busy   high while a sweep is in progress (DRIVE or GAP)
//   o_done   one-cycle pulse at the natural end of a one-shot sweep
// -----------------------------------------------------------------------------
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_mode,
  input  logic [7:0] i_mask,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_en,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  // The counter counts down to zero, so it is loaded with "cycles - 1".
  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LOAD = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;
  localparam bit         HAS_GAP    = (BLANK > 0);

  state_t     r_state;
  logic [7:0] r_mreg;   // channel mask latched at start
  logic       r_mdreg;  // mode latched at start
  logic [2:0] r_ch;     // current channel index, drives {a,b,c}
  logic [7:0] r_cnt;    // dwell / gap down-counter
  logic       r_en;
  logic       r_busy;
  logic       r_done;

  logic [2:0] w_start_ch;  // lowest set bit of the incoming mask
  logic [2:0] w_first_ch;  // lowest set bit of the latched mask
  logic [2:0] w_next_ch;   // channel that follows r_ch (wrapped if needed)
  logic       w_wrap;      // no set bit above r_ch
  logic       w_accept;    // start request taken this cycle
  logic       w_eoc;       // current channel's dwell/gap period is over
  logic       w_finish;    // end of channel that also ends a one-shot sweep

  // ---------------------------------------------------------------------------
  // Channel selection. The loops run from the top bit down, so the last match
  // assigned is the lowest qualifying bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    w_start_ch = 3'd0;
    w_first_ch = 3'd0;
    w_next_ch  = 3'd0;
    w_wrap     = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_start_ch = 3'(i);
      end
      if (r_mreg[i]) begin
        w_first_ch = 3'(i);
      end
      if (r_mreg[i] && (i > int'(r_ch))) begin
        w_next_ch = 3'(i);
        w_wrap    = 1'b0;
      end
    end
    if (w_wrap) begin
      w_next_ch = w_first_ch;
    end
  end

  assign w_accept = i_start && !i_stop && (i_mask != 8'd0);

  // With BLANK = 0 the channel ends straight out of DRIVE; otherwise the gap
  // expiring is what ends the channel.
  assign w_eoc = (r_cnt == 8'd0) &&
                 (((r_state == S_DRIVE) && !HAS_GAP) || (r_state == S_GAP));

  assign w_finish = w_wrap && !r_mdreg;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the values from before this clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mreg  <= 8'd0;
      r_mdreg <= 1'b0;
      r_ch    <= 3'd0;
      r_cnt   <= 8'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // done is a pulse; it is raised only by the one-shot completion below.
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mreg  <= i_mask;
            r_mdreg <= i_mode;
            r_ch    <= w_start_ch;
            r_cnt   <= DWELL_LOAD;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_DRIVE;
          end
        end

        S_DRIVE, S_GAP: begin
          if (i_stop) begin
            // Abort: channel index is left where it was, no done pulse.
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_eoc) begin
            if (w_finish) begin
              r_en    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              // Covers both the plain advance and the continuous-mode wrap:
              // w_next_ch already falls back to the lowest channel.
              r_ch    <= w_next_ch;
              r_cnt   <= DWELL_LOAD;
              r_en    <= 1'b1;
              r_state <= S_DRIVE;
            end
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Dwell over and a gap follows (BLANK > 0 is implied here).
            r_cnt   <= BLANK_LOAD;
            r_en    <= 1'b0;
            r_state <= S_GAP;
          end
        end

        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_a    = r_ch[2];
  assign o_b    = r_ch[1];
  assign o_c    = r_ch[0];
  assign o_en   = r_en;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//
// Three sequencer instances with different DWELL/BLANK settings share a clock
// and reset. Each scenario task pushes the expected cycle-by-cycle trace of
// {ch, en, busy, done} into a scoreboard queue as it drives stimulus, then pops
// one entry per cycle and compares it with what the instance produces.
//   unit 0: DWELL=4, BLANK=1
//   unit 1: DWELL=2, BLANK=0
//   unit 2: DWELL=3, BLANK=2
// -----------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

  localparam int NU = 3;

  typedef struct packed {
    logic [2:0] ch;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [NU-1:0] start;
  logic [NU-1:0] stop;
  logic [NU-1:0] mode;
  logic [7:0]    mask [NU];
  logic [NU-1:0] a, b, c, en, busy, done;

  obs_t sb [$];
  int   n_checks;
  int   n_errors;
  int   last_ch [NU];

  decoder_scan_sequencer #(.DWELL(4), .BLANK(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_stop(stop[0]),
    .i_mode(mode[0]), .i_mask(mask[0]),
    .o_a(a[0]), .o_b(b[0]), .o_c(c[0]), .o_en(en[0]), .o_busy(busy[0]),
    .o_done(done[0])
  );

  decoder_scan_sequencer #(.DWELL(2), .BLANK(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_stop(stop[1]),
    .i_mode(mode[1]), .i_mask(mask[1]),
    .o_a(a[1]), .o_b(b[1]), .o_c(c[1]), .o_en(en[1]), .o_busy(busy[1]),
    .o_done(done[1])
  );

  decoder_scan_sequencer #(.DWELL(3), .BLANK(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_stop(stop[2]),
    .i_mode(mode[2]), .i_mask(mask[2]),
    .o_a(a[2]), .o_b(b[2]), .o_c(c[2]), .o_en(en[2]), .o_busy(busy[2]),
    .o_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dwell_of(int u);
    case (u)
      0:       return 4;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int blank_of(int u);
    case (u)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic obs_t observe(int u);
    obs_t o;
    o.ch   = {a[u], b[u], c[u]};
    o.en   = en[u];
    o.busy = busy[u];
    o.done = done[u];
    return o;
  endfunction

  function automatic string show(obs_t o);
    return $sformatf("ch=%0d en=%b busy=%b done=%b", o.ch, o.en, o.busy, o.done);
  endfunction

  // Advance one clock; outputs are then sampled 1 ns after the edge. Single
  // cycle requests are withdrawn as soon as the edge has sampled them.
  task automatic step();
    @(posedge clk);
    #1;
    start = '0;
    stop  = '0;
  endtask

  // ---- expected-trace model ----
  task automatic push_visit(int u, int ch);
    obs_t o;
    o.ch = 3'(ch);
    o.done = 1'b0;
    o.busy = 1'b1;
    o.en = 1'b1;
    for (int i = 0; i < dwell_of(u); i++) sb.push_back(o);
    o.en = 1'b0;
    for (int i = 0; i < blank_of(u); i++) sb.push_back(o);
    last_ch[u] = ch;
  endtask

  task automatic push_sweep(int u, logic [7:0] m, int visits);
    int n;
    n = 0;
    while (n < visits) begin
      for (int i = 0; i < 8; i++) begin
        if (m[i] && (n < visits)) begin
          push_visit(u, i);
          n++;
        end
      end
    end
  endtask

  task automatic push_done(int u);
    obs_t o;
    o.ch = 3'(last_ch[u]);
    o.en = 1'b0;
    o.busy = 1'b0;
    o.done = 1'b1;
    sb.push_back(o);
  endtask

  task automatic push_idle(int u, int n);
    obs_t o;
    o.ch = 3'(last_ch[u]);
    o.en = 1'b0;
    o.busy = 1'b0;
    o.done = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(o);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    obs_t got;
    rst   = 1'b1;
    start = '0;
    stop  = '0;
    mode  = '0;
    for (int u = 0; u < NU; u++) begin
      mask[u]    = 8'd0;
      last_ch[u] = 0;
    end
    step();
    step();
    rst = 1'b0;
    step();
    for (int u = 0; u < NU; u++) begin
      got = observe(u);
      n_checks++;
      if (got !== obs_t'(6'd0)) begin
        n_errors++;
        $display("FAIL reset_state[u%0d]: got %s, want all zero", u, show(got));
      end
    end
  endtask

  task automatic test_reset_mid_drive();
    obs_t got, exp;
    push_visit(0, 2);
    mask[0] = 8'h24;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_mid_pre[%0d]: got %s, want %s", k, show(got), show(exp));
      end
    end
    sb.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_ch[0] = 0;
    got = observe(0);
    n_checks++;
    if (got !== obs_t'(6'd0)) begin
      n_errors++;
      $display("FAIL reset_mid_drive: got %s, want all zero", show(got));
    end
  endtask

  task automatic test_one_shot();
    obs_t got, exp;
    int idx, busy_cnt, done_cnt;
    idx = 0;
    busy_cnt = 0;
    done_cnt = 0;
    push_sweep(0, 8'b1010_0101, 4);
    push_done(0);
    push_idle(0, 2);
    mask[0] = 8'b1010_0101;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      if (got.busy === 1'b1) busy_cnt++;
      if (got.done === 1'b1) done_cnt++;
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL one_shot[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      idx++;
    end
    n_checks++;
    if (busy_cnt != 20) begin
      n_errors++;
      $display("FAIL one_shot_busy_len: got %0d, want 20", busy_cnt);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++;
      $display("FAIL one_shot_done_count: got %0d, want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int idx;
    bit restarted;
    idx = 0;
    restarted = 1'b0;
    push_sweep(0, 8'h02, 1);
    push_done(0);
    push_sweep(0, 8'h40, 1);
    push_done(0);
    push_idle(0, 1);
    mask[0] = 8'h02;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      // Restart in the done cycle of the first sweep.
      if (exp.done && !restarted) begin
        restarted = 1'b1;
        mask[0]   = 8'h40;
        start[0]  = 1'b1;
      end
      idx++;
    end
  endtask

  task automatic test_continuous_wrap();
    obs_t got, exp;
    int idx;
    idx = 0;
    push_sweep(1, 8'h81, 5);
    push_idle(1, 1);
    mask[1] = 8'h81;
    mode[1] = 1'b1;
    start[1] = 1'b1;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(1);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL continuous_wrap[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      if (sb.size() == 1) stop[1] = 1'b1;
      idx++;
    end
  endtask

  task automatic test_stop_mid_sweep();
    obs_t got, exp, o;
    int idx;
    idx = 0;
    push_visit(0, 0);
    o.ch = 3'd2;
    o.en = 1'b1;
    o.busy = 1'b1;
    o.done = 1'b0;
    sb.push_back(o);
    sb.push_back(o);
    last_ch[0] = 2;
    push_idle(0, 3);
    mask[0] = 8'b1010_0101;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL stop_mid_sweep[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      // After the second DRIVE cycle of channel 2, abort.
      if (sb.size() == 3 && idx == 6) stop[0] = 1'b1;
      idx++;
    end
  endtask

  task automatic test_start_edge_cases();
    obs_t got, exp;
    int idx;
    // start with an empty mask
    push_idle(0, 3);
    mask[0] = 8'h00;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    idx = 0;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start_mask_zero[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      idx++;
    end
    // start and stop together
    push_idle(0, 3);
    mask[0] = 8'hFF;
    start[0] = 1'b1;
    stop[0] = 1'b1;
    idx = 0;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start_with_stop[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      idx++;
    end
    // start, mask and mode changes while busy
    push_sweep(0, 8'h81, 2);
    push_done(0);
    push_idle(0, 1);
    mask[0] = 8'h81;
    mode[0] = 1'b0;
    start[0] = 1'b1;
    idx = 0;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(0);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL start_while_busy[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      if (idx == 2) begin
        mask[0]  = 8'h3C;
        mode[0]  = 1'b1;
        start[0] = 1'b1;
      end
      idx++;
    end
  endtask

  task automatic test_single_channel_continuous();
    obs_t got, exp;
    int idx;
    idx = 0;
    push_sweep(2, 8'h10, 3);
    push_idle(2, 1);
    mask[2] = 8'h10;
    mode[2] = 1'b1;
    start[2] = 1'b1;
    while (sb.size() > 0) begin
      step();
      exp = sb.pop_front();
      got = observe(2);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL single_channel_cont[%0d]: got %s, want %s", idx, show(got), show(exp));
      end
      if (sb.size() == 1) stop[2] = 1'b1;
      idx++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_reset_mid_drive();
    test_one_shot();
    test_back_to_back();
    test_continuous_wrap();
    test_stop_mid_sweep();
    test_start_edge_cases();
    test_single_channel_continuous();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Registered scan sequencer that drives the select lines (`a`, `b`, `c`) and enable (`en`) of the 3-to-8 decoder stage directly downstream. It steps through a programmable subset of the eight decoder outputs, holding each for a fixed dwell time with an optional blanking gap between channels. It supports one-shot and continuous sweeps, and is used for row/digit multiplexing and channel strobing.

## Interface
- `DWELL`, default 4: cycles `en` is held high per visited channel; legal range 1..255.
- `BLANK`, default 1: cycles `en` is held low between consecutive channels; legal range 0..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a sweep; sampled only in IDLE.
- `stop` in 1: abort the sweep; sampled in every state.
- `mode` in 1: 0 = one-shot sweep, 1 = continuous; latched with `start`.
- `mask` in 8: bit i = 1 means visit channel i; latched with `start`.
- `a` out 1: select MSB of the channel index.
- `b` out 1: select middle bit of the channel index.
- `c` out 1: select LSB of the channel index.
- `en` out 1: decoder enable; high only in DRIVE.
- `busy` out 1: high in DRIVE and GAP.
- `done` out 1: one-cycle pulse at the natural end of a one-shot sweep.

## Operation
- States: IDLE, DRIVE, GAP. Internal registers:
  - latched mask `mreg` and mode `mdreg`;
  - 3-bit channel index `ch`, with `{a,b,c} = ch`;
  - 8-bit dwell/gap counter `cnt`.
- Next-channel function: the lowest set bit of `mreg` strictly above `ch`. If none exists, the lowest set bit of `mreg` and a wrap flag.
- IDLE:
  - `start`=1, `stop`=0 and `mask`≠0: latch `mask` and `mode`, set `ch` to the lowest set bit of `mask`, load `cnt`, go to DRIVE.
  - `start` with `mask`=0: ignored; stay in IDLE.
- DRIVE: `en`=1 and `ch` held stable. After DWELL cycles:
  - BLANK>0: go to GAP.
  - BLANK=0: advance directly, using the end-of-channel rule below.
- GAP: `en`=0 and `ch` held. After BLANK cycles, apply the end-of-channel rule.
- End-of-channel rule:
  - No wrap: `ch` becomes the next channel; go to DRIVE.
  - Wrap with `mdreg`=1: `ch` becomes the lowest set bit of `mreg`; go to DRIVE.
  - Wrap with `mdreg`=0: go to IDLE and pulse `done`.
- `stop`=1 in DRIVE or GAP: the next state is IDLE, `en`=0 and `busy`=0 on the next cycle, no `done`. `ch` keeps its last value.
- `start` while `busy`: ignored. `mask`/`mode` changes while `busy`: ignored.
- `start` and `stop` in the same IDLE cycle: `stop` wins; stay in IDLE.
- A single set mask bit in continuous mode revisits the same channel, with GAP between visits when BLANK>0.

## Timing
- All outputs are registered. Reset values: `a`=`b`=`c`=0, `en`=0, `busy`=0, `done`=0, state IDLE, `mreg`=0.
- `rst` overrides `start`/`stop` and aborts mid-sweep: all outputs return to reset values at the next edge.
- Latency: `start` sampled at edge k gives `en`=1, `busy`=1 and `{a,b,c}` = first channel during cycle k+1.
- Per-channel period: DWELL+BLANK cycles. `en` high for exactly DWELL consecutive cycles per visit.
- `{a,b,c}` changes only on the edge that begins a DRIVE:
  - BLANK>0: it never changes while `en`=1.
  - BLANK=0: it changes between two `en`=1 cycles, and `en` stays continuously high.
- One-shot sweep length, with N set mask bits: N·(DWELL+BLANK) cycles of `busy`=1. `done`=1 for exactly one cycle, the first cycle after the sweep ends, with `busy`=0 and `en`=0 in that cycle.
- A `start` in the `done` cycle is accepted, giving back-to-back sweeps with one idle cycle.

## Test plan
- **Reset:** assert `rst` mid-DRIVE → next cycle `en`=0, `busy`=0, `{a,b,c}`=000, `done`=0; a later `start` works normally.
- **One-shot sweep:** DWELL=4, BLANK=1, `mask`=8'b1010_0101, `mode`=0 → channels 0, 2, 5, 7 in order; each has `en` high 4 cycles, then low 1; `busy` high 20 cycles; `done` pulses once; the `{a,b,c}` sequence is 000, 010, 101, 111.
- **Continuous wrap:** DWELL=2, BLANK=0, `mask`=8'h81, `mode`=1 → `en` stays high; `ch` alternates 000, 111, 000 every 2 cycles; `done` never fires.
- **Stop mid-sweep:** raise `stop` in cycle 2 of channel 2 DRIVE → the next cycle is IDLE with `en`=0 and `busy`=0, `{a,b,c}`=010 held, no `done`.
- **Start edge cases:**
  - `start` with `mask`=0 → no response.
  - `start`+`stop` together in IDLE → no response.
  - `start` while `busy` with a new `mask` → sweep unchanged.
- **Single-channel continuous:** `mask`=8'h10, DWELL=3, BLANK=2 → `{a,b,c}`=100 constant; `en` pattern is 1,1,1,0,0 repeating.
